// File: rtl/vga_fx_sequencer_if.sv
// Control, script-write and status bundle between the VGA top level
// and the noise-overlay scene sequencer.
interface vga_fx_sequencer_if #(
  parameter int ADDR_W = 3
);
  // timing inputs from hvsync_generator
  logic              vsync;
  logic              display_on;
  // sequencing controls
  logic              run;
  logic              loop;
  logic [ADDR_W-1:0] last_idx;
  // script table write port: {reseed, mask[7:0], dur[7:0]}
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [16:0]       wr_data;
  // overlay outputs and status
  logic [7:0]        noise_mask;
  logic              pcg_en;
  logic              pcg_reseed;
  logic [ADDR_W-1:0] scene_idx;
  logic [7:0]        frame_cnt;
  logic              busy;

  // driver side: timing source, controller and script loader
  modport master (
    output vsync, display_on, run, loop, last_idx, wr_en, wr_addr, wr_data,
    input  noise_mask, pcg_en, pcg_reseed, scene_idx, frame_cnt, busy
  );

  // sequencer side
  modport slave (
    input  vsync, display_on, run, loop, last_idx, wr_en, wr_addr, wr_data,
    output noise_mask, pcg_en, pcg_reseed, scene_idx, frame_cnt, busy
  );
endinterface

// File: rtl/vga_fx_sequencer.sv
// Frame-synchronous scene scheduler for the PCG noise overlay.
// Steps through a small script table on vsync frame ticks, drives the
// noise mask (only ever changed on a tick, so it is tear-free), gates
// PCG advance to active video and issues one-cycle reseed requests.
module vga_fx_sequencer #(
  parameter int   DEPTH        = 8,
  parameter int   ADDR_W       = 3,
  parameter logic VSYNC_ACTIVE = 1'b1
) (
  input logic                clk,
  input logic                reset,
  vga_fx_sequencer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // what the current cycle does to the sequencer state
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_STOP,
    ACT_ADV
  } action_t;

  typedef struct packed {
    logic       reseed;
    logic [7:0] mask;
    logic [7:0] dur;
  } entry_t;

  entry_t            script_mem [DEPTH];
  logic              vsync_q;
  logic              tick;
  state_t            state;
  logic              busy;
  logic [7:0]        noise_mask;
  logic [7:0]        frame_cnt;
  logic [7:0]        dur_q;
  logic [ADDR_W-1:0] scene_idx;
  logic              pcg_reseed;
  logic              scene_end;
  logic              at_last;
  logic [ADDR_W-1:0] next_idx;
  action_t           act;
  logic [ADDR_W-1:0] load_idx;
  entry_t            load_entry;

  // Delay vsync one clock for start-of-pulse detection; the reset value
  // equals the active level so reset release never looks like a pulse start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vsync_q <= VSYNC_ACTIVE;
    else       vsync_q <= bus.vsync;
  end

  assign tick = (bus.vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);

  // Script table: writable at any time; reset clears every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: reset on a memory turns it into plain flops; intended here because the table must come up cleared.
      for (int i = 0; i < DEPTH; i++) script_mem[i] <= '0;
    end else if (bus.wr_en) begin
      script_mem[bus.wr_addr] <= entry_t'(bus.wr_data);
    end
  end

  // dur=0 wraps to 255 here, which makes a zero duration last 256 frames.
  assign scene_end = (frame_cnt == (dur_q - 8'd1));
  assign at_last   = (scene_idx == bus.last_idx);
  assign next_idx  = scene_idx + ADDR_W'(1);

  // Decide what this frame tick does; nothing happens between ticks.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    act      = ACT_HOLD;
    load_idx = '0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (bus.run) act = ACT_LOAD;
        end
        RUN: begin
          if (!bus.run) begin
            act = ACT_STOP;
          end else if (scene_end) begin
            if (!at_last) begin
              // a lowered last_idx below scene_idx lets this roll over naturally
              act      = ACT_LOAD;
              load_idx = next_idx;
            end else if (bus.loop) begin
              act = ACT_LOAD;
            end else begin
              act = ACT_STOP;
            end
          end else begin
            act = ACT_ADV;
          end
        end
        default: act = ACT_HOLD;
      endcase
    end
  end

  // Reads the pre-write contents when a write hits the entry being loaded.
  assign load_entry = script_mem[load_idx];

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      noise_mask <= '0;
      scene_idx  <= '0;
      frame_cnt  <= '0;
      dur_q      <= '0;
      pcg_reseed <= 1'b0;
    end else begin
      // NOTE: non-blocking default then override gives a clean one-cycle pulse.
      pcg_reseed <= 1'b0;
      unique case (act)
        ACT_LOAD: begin
          state      <= RUN;
          busy       <= 1'b1;
          scene_idx  <= load_idx;
          frame_cnt  <= '0;
          noise_mask <= load_entry.mask;
          dur_q      <= load_entry.dur;
          pcg_reseed <= load_entry.reseed;
        end
        ACT_STOP: begin
          state      <= IDLE;
          busy       <= 1'b0;
          scene_idx  <= '0;
          frame_cnt  <= '0;
          noise_mask <= '0;
        end
        ACT_ADV: begin
          frame_cnt <= frame_cnt + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.noise_mask = noise_mask;
  assign bus.scene_idx  = scene_idx;
  assign bus.frame_cnt  = frame_cnt;
  assign bus.busy       = busy;
  assign bus.pcg_reseed = pcg_reseed;
  // PCG only advances on visible pixels of a running scene.
  assign bus.pcg_en     = busy & bus.display_on;

endmodule

// File: tb/tb_vga_fx_sequencer.sv
// Bench for vga_fx_sequencer: the stimulus side keeps a frame-level model
// of the scene script and queues the expected state after every frame tick;
// a monitor pops that on each tick and checks outputs every cycle.
module tb_vga_fx_sequencer;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_fx_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  vga_fx_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .VSYNC_ACTIVE(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic       reseed;
    logic [7:0] mask;
    logic [7:0] dur;
  } entry_t;

  typedef struct packed {
    logic [7:0]        mask;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        cnt;
    logic              busy;
    logic              reseed;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  entry_t     m_tab [DEPTH];
  bit         m_busy;
  int         m_idx, m_cnt, m_dur;
  logic [7:0] m_mask;
  bit         m_reseed;
  bit         m_prev_v;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
    m_busy = 0; m_idx = 0; m_cnt = 0; m_dur = 256;
    m_mask = '0; m_reseed = 0; m_prev_v = 1;
  endfunction

  function automatic void model_load(input int k);
    m_busy   = 1;
    m_idx    = k;
    m_cnt    = 0;
    m_mask   = m_tab[k].mask;
    m_dur    = (m_tab[k].dur == 0) ? 256 : int'(m_tab[k].dur);
    m_reseed = m_tab[k].reseed;
  endfunction

  function automatic void model_stop();
    m_busy = 0; m_idx = 0; m_cnt = 0; m_mask = '0;
  endfunction

  // Drive one clock cycle (called at a falling edge), advance the model
  // for the coming rising edge, then wait for the next falling edge.
  task automatic cyc(input logic v);
    exp_t e;
    bit   tk;
    bus.vsync      = v;
    bus.display_on = 1'($urandom);
    tk       = v && !m_prev_v;
    m_prev_v = v;
    if (tk) begin
      m_reseed = 0;
      if (!m_busy) begin
        if (bus.run) model_load(0);
      end else if (!bus.run) begin
        model_stop();
      end else if (m_cnt + 1 == m_dur) begin
        if (m_idx != int'(bus.last_idx)) model_load((m_idx + 1) % DEPTH);
        else if (bus.loop)               model_load(0);
        else                             model_stop();
      end else begin
        m_cnt++;
      end
      e.mask   = m_mask;
      e.idx    = ADDR_W'(m_idx);
      e.cnt    = 8'(m_cnt);
      e.busy   = m_busy;
      e.reseed = m_reseed;
      sb_q.push_back(e);
    end
    // table write lands after the load, so a same-cycle load sees old data
    if (bus.wr_en) m_tab[bus.wr_addr] = entry_t'(bus.wr_data);
    @(negedge clk);
  endtask

  task automatic frame();
    cyc(1'b1);
    cyc(1'b1);
    repeat (6) cyc(1'b0);
  endtask

  task automatic write_entry(input int addr, input logic rs, input logic [7:0] mask,
                             input logic [7:0] dur);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(addr);
    bus.wr_data = {rs, mask, dur};
    cyc(1'b0);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.loop       = 1'b0;
    bus.last_idx   = '0;
    bus.wr_en      = 1'b0;
    bus.vsync      = 1'b0;
    model_reset();
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t       cur;
    logic       mon_vq;
    logic [21:0] obs, req;
    cur    = '0;
    mon_vq = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        cur    = '0;
        mon_vq = 1'b1;
      end else begin
        if (bus.vsync && !mon_vq) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow@%0t: tick seen with no expected entry", $time);
          end else begin
            cur = sb_q.pop_front();
          end
        end else begin
          cur.reseed = 1'b0;
        end
        mon_vq = bus.vsync;
        obs = {bus.noise_mask, bus.scene_idx, bus.frame_cnt, bus.busy, bus.pcg_reseed, bus.pcg_en};
        req = {cur, cur.busy & bus.display_on};
        check($sformatf("outputs@%0t", $time), 32'(obs), 32'(req));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.vsync = 1'b0; bus.display_on = 1'b0; bus.run = 1'b0; bus.loop = 1'b0;
    bus.last_idx = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: idle frames with run=0
    cyc(1'b0);
    repeat (3) frame();
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_mask", 32'(bus.noise_mask), 0);

    // 2: two-entry looping script
    do_reset();
    write_entry(0, 1'b1, 8'hF0, 8'd2);
    write_entry(1, 1'b0, 8'h0F, 8'd1);
    bus.last_idx = 3'd1; bus.loop = 1'b1; bus.run = 1'b1;
    frame();
    check("loop_t1_mask", 32'(bus.noise_mask), 32'h0F0);
    check("loop_t1_idx", 32'(bus.scene_idx), 0);
    frame();
    frame();
    check("loop_t3_mask", 32'(bus.noise_mask), 32'h00F);
    check("loop_t3_idx", 32'(bus.scene_idx), 1);
    frame();
    check("loop_t4_mask", 32'(bus.noise_mask), 32'h0F0);

    // 3: same script without looping, then restart while run stays high
    do_reset();
    write_entry(0, 1'b1, 8'hF0, 8'd2);
    write_entry(1, 1'b0, 8'h0F, 8'd1);
    bus.last_idx = 3'd1; bus.loop = 1'b0; bus.run = 1'b1;
    repeat (4) frame();
    check("once_t4_busy", 32'(bus.busy), 0);
    check("once_t4_mask", 32'(bus.noise_mask), 0);
    frame();
    check("once_t5_busy", 32'(bus.busy), 1);
    check("once_t5_mask", 32'(bus.noise_mask), 32'h0F0);

    // 4: drop run mid-frame
    cyc(1'b1); cyc(1'b1); cyc(1'b0);
    bus.run = 1'b0;
    repeat (5) cyc(1'b0);
    check("stop_hold_mask", 32'(bus.noise_mask), 32'h0F0);
    frame();
    check("stop_mask", 32'(bus.noise_mask), 0);
    check("stop_busy", 32'(bus.busy), 0);

    // 5: rewrite the active entry mid-scene
    do_reset();
    write_entry(0, 1'b1, 8'hF0, 8'd2);
    write_entry(1, 1'b0, 8'h0F, 8'd1);
    bus.last_idx = 3'd1; bus.loop = 1'b1; bus.run = 1'b1;
    frame();
    write_entry(0, 1'b1, 8'h55, 8'd2);
    check("rewrite_hold0", 32'(bus.noise_mask), 32'h0F0);
    frame();
    check("rewrite_hold1", 32'(bus.noise_mask), 32'h0F0);
    frame();
    frame();
    check("rewrite_new", 32'(bus.noise_mask), 32'h055);

    // 6: dur=0 means 256 frames, then async reset mid-run
    do_reset();
    write_entry(0, 1'b1, 8'hAA, 8'd0);
    bus.last_idx = 3'd0; bus.loop = 1'b1; bus.run = 1'b1;
    repeat (256) frame();
    check("dur256_cnt255", 32'(bus.frame_cnt), 255);
    frame();
    check("dur256_wrap", 32'(bus.frame_cnt), 0);
    check("dur256_mask", 32'(bus.noise_mask), 32'h0AA);
    bus.display_on = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", 32'({bus.noise_mask, bus.scene_idx, bus.frame_cnt, bus.busy,
                              bus.pcg_reseed, bus.pcg_en}), 0);
    @(negedge clk);
    do_reset();

    // 7: randomized scripts, controls, frame shapes and writes
    cyc(1'b0);
    for (int i = 0; i < DEPTH; i++)
      write_entry(i, 1'($urandom), 8'($urandom), 8'($urandom_range(1, 3)));
    bus.run = 1'b1; bus.loop = 1'b1; bus.last_idx = ADDR_W'($urandom);
    for (int f = 0; f < 120; f++) begin
      int hi, lo;
      bus.run      = ($urandom_range(0, 7) != 0);
      bus.loop     = ($urandom_range(0, 3) != 0);
      bus.last_idx = ADDR_W'($urandom);
      hi = $urandom_range(1, 2);
      lo = $urandom_range(1, 5);
      for (int c = 0; c < hi + lo; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = ADDR_W'($urandom);
          bus.wr_data = {1'($urandom), 8'($urandom), 8'($urandom_range(1, 3))};
        end
        if ($urandom_range(0, 9) == 0) bus.run = ~bus.run;
        cyc(c < hi);
        bus.wr_en = 1'b0;
      end
    end
    repeat (2) cyc(1'b0);
    check("sb_drain", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
